// File: rtl/iseq_loader.sv
// iseq_loader: producer side of the two instruction-sequence FIFOs.
// Host words go alternately to slot 0 and slot 1, starting with slot 0.
// An END word closes the sequence. If the sequence has an odd length, a NOP
// is written to slot 1 so both FIFOs end up holding the same number of words.
// The dispatcher is then started with a one-cycle pulse, and the host is held
// off until the dispatcher has finished.
//
// state     | meaning
// ----------+------------------------------------------------------------
// LOAD      | accepting host words, routing them to slot 0 or slot 1
// PAD       | odd-length sequence: write a NOP into slot 1
// START     | one-cycle process_iseq pulse; latch seq_len; clear cnt and slot
// WAIT_ACK  | wait for dispatcher_busy to rise
// WAIT_DONE | wait for dispatcher_busy to fall, then return to LOAD
module iseq_loader #(
    parameter int          OPC_MSB   = 31,
    parameter logic [3:0]  END_OPC   = 4'hF,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 host_valid,
    input  logic [31:0]          host_data,
    output logic                 host_ready,
    output logic                 instr0_fifo_wr,
    input  logic                 instr0_fifo_full,
    output logic [31:0]          instr0_fifo_data,
    output logic                 instr1_fifo_wr,
    input  logic                 instr1_fifo_full,
    output logic [31:0]          instr1_fifo_data,
    output logic                 process_iseq,
    input  logic                 dispatcher_busy,
    output logic                 loader_busy,
    output logic [CNT_WIDTH-1:0] seq_len
);

    localparam logic [2:0] S_LOAD      = 3'd0;
    localparam logic [2:0] S_PAD       = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]           state_q, state_d;
    logic                 slot_q, slot_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] seq_len_q, seq_len_d;

    logic is_end;
    logic target_full;
    logic ready;
    logic wr0, wr1;
    logic pulse;
    logic [31:0] data1;

    assign is_end      = (host_data[OPC_MSB -: 4] == END_OPC);
    assign target_full = slot_q ? instr1_fifo_full : instr0_fifo_full;

    // Next-state, routing and strobe generation.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        seq_len_d = seq_len_q;
        ready     = 1'b0;
        wr0       = 1'b0;
        wr1       = 1'b0;
        pulse     = 1'b0;
        data1     = host_data;
        case (state_q)
            S_LOAD: begin
                // END is always accepted; it is never written, so full does not block it.
                ready = ~target_full | is_end;
                if (host_valid && ready) begin
                    if (!is_end) begin
                        wr0    = ~slot_q;
                        wr1    = slot_q;
                        slot_d = ~slot_q;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else if (cnt_q != '0) begin
                        state_d = slot_q ? S_PAD : S_START;
                    end
                end
            end
            S_PAD: begin
                data1 = NOP_INSTR;
                if (!instr1_fifo_full) begin
                    wr1     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                pulse     = 1'b1;
                seq_len_d = cnt_q;
                cnt_d     = '0;
                slot_d    = 1'b0;
                state_d   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (dispatcher_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!dispatcher_busy) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State, slot, counter and sequence-length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOAD;
            slot_q    <= 1'b0;
            cnt_q     <= '0;
            seq_len_q <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            seq_len_q <= seq_len_d;
        end
    end

    assign host_ready       = ready;
    assign instr0_fifo_wr   = wr0;
    assign instr1_fifo_wr   = wr1;
    assign instr0_fifo_data = host_data;
    assign instr1_fifo_data = data1;
    assign process_iseq     = pulse;
    assign loader_busy      = (state_q != S_LOAD);
    assign seq_len          = seq_len_q;

endmodule

// File: tb/tb_iseq_loader.sv
// Testbench for iseq_loader: directed streams with a queue-based scoreboard.
module tb_iseq_loader;

    localparam logic [31:0] A   = 32'h1000_000A;
    localparam logic [31:0] B   = 32'h2000_000B;
    localparam logic [31:0] C   = 32'h3000_000C;
    localparam logic [31:0] EN  = 32'hF000_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_valid = 1'b0;
    logic [31:0] host_data = 32'h0;
    logic        host_ready;
    logic        instr0_fifo_wr, instr1_fifo_wr;
    logic        instr0_fifo_full = 1'b0, instr1_fifo_full = 1'b0;
    logic [31:0] instr0_fifo_data, instr1_fifo_data;
    logic        process_iseq;
    logic        dispatcher_busy = 1'b0;
    logic        loader_busy;
    logic [15:0] seq_len;

    int tests = 0;
    int failed = 0;

    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    logic [15:0] exp_len[$];

    int slot_m = 0;
    int cnt_m  = 0;

    iseq_loader dut (
        .clk(clk), .rst_n(rst_n),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .instr0_fifo_wr(instr0_fifo_wr), .instr0_fifo_full(instr0_fifo_full),
        .instr0_fifo_data(instr0_fifo_data),
        .instr1_fifo_wr(instr1_fifo_wr), .instr1_fifo_full(instr1_fifo_full),
        .instr1_fifo_data(instr1_fifo_data),
        .process_iseq(process_iseq), .dispatcher_busy(dispatcher_busy),
        .loader_busy(loader_busy), .seq_len(seq_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: decides where each word should land and what seq_len to expect.
    task automatic model(input logic [31:0] w);
        if (w[31:28] == 4'hF) begin
            if (cnt_m > 0) begin
                if (slot_m == 1) exp1.push_back(NOP);
                exp_len.push_back(16'(cnt_m));
            end
            cnt_m  = 0;
            slot_m = 0;
        end else begin
            if (slot_m == 0) exp0.push_back(w); else exp1.push_back(w);
            slot_m = 1 - slot_m;
            if (cnt_m < 65535) cnt_m++;
        end
    endtask

    // Present one word and hold it until accepted (caller aligned to posedge+1).
    task automatic send(input logic [31:0] w);
        int n;
        model(w);
        host_valid = 1'b1;
        host_data  = w;
        n = 0;
        @(negedge clk);
        while (!host_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!host_ready) chk("send_timeout", 32'(host_ready), 32'd1);
        @(posedge clk); #1;
        host_valid = 1'b0;
    endtask

    // Dispatcher handshake: host held off through WAIT_ACK and WAIT_DONE.
    task automatic dispatch(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_ready_wait_ack"}, 32'(host_ready), 32'd0);
        chk({tag, "_busy_wait_ack"}, 32'(loader_busy), 32'd1);
        @(posedge clk); #1; dispatcher_busy = 1'b1;
        repeat (3) @(negedge clk);
        chk({tag, "_ready_wait_done"}, 32'(host_ready), 32'd0);
        @(posedge clk); #1; dispatcher_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_ready_after"}, 32'(host_ready), 32'd1);
        chk({tag, "_busy_after"}, 32'(loader_busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic queues_empty(input string tag);
        chk({tag, "_q0_left"}, 32'(exp0.size()), 32'd0);
        chk({tag, "_q1_left"}, 32'(exp1.size()), 32'd0);
        chk({tag, "_pulse_left"}, 32'(exp_len.size()), 32'd0);
    endtask

    // Monitor: pop and compare on every strobe and start pulse.
    logic len_pending = 1'b0;
    logic [15:0] len_req;
    always @(negedge clk) begin
        if (rst_n) begin
            if (len_pending) begin
                chk("seq_len", 32'(seq_len), 32'(len_req));
                len_pending = 1'b0;
            end
            if (instr0_fifo_wr) begin
                chk("wr0_while_full", 32'(instr0_fifo_full), 32'd0);
                if (exp0.size() == 0) chk("wr0_unexpected", instr0_fifo_data, 32'hDEAD_BEEF);
                else chk("slot0_data", instr0_fifo_data, exp0.pop_front());
            end
            if (instr1_fifo_wr) begin
                chk("wr1_while_full", 32'(instr1_fifo_full), 32'd0);
                if (exp1.size() == 0) chk("wr1_unexpected", instr1_fifo_data, 32'hDEAD_BEEF);
                else chk("slot1_data", instr1_fifo_data, exp1.pop_front());
            end
            if (process_iseq) begin
                chk("pulse_vs_fifo_balance", 32'(exp0.size()), 32'(exp1.size()));
                if (exp_len.size() == 0) chk("pulse_unexpected", 32'd1, 32'd0);
                else begin
                    len_req     = exp_len.pop_front();
                    len_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_strobe0", 32'(instr0_fifo_wr), 32'd0);
        chk("rst_strobe1", 32'(instr1_fifo_wr), 32'd0);
        chk("rst_pulse", 32'(process_iseq), 32'd0);
        chk("rst_seq_len", 32'(seq_len), 32'd0);
        chk("rst_loader_busy", 32'(loader_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: odd sequence, padded
        send(A); send(B); send(C); send(EN);
        dispatch("t1");
        queues_empty("t1");

        // 2: even sequence, no pad
        send(A); send(B); send(EN);
        dispatch("t2");
        queues_empty("t2");

        // 3: slot-1 full while B is presented
        send(A);
        instr1_fifo_full = 1'b1;
        model(B);
        host_valid = 1'b1; host_data = B;
        repeat (3) begin
            @(negedge clk);
            chk("t3_ready_full", 32'(host_ready), 32'd0);
            chk("t3_wr1_full", 32'(instr1_fifo_wr), 32'd0);
        end
        @(posedge clk); #1; instr1_fifo_full = 1'b0;
        @(negedge clk);
        chk("t3_ready_after", 32'(host_ready), 32'd1);
        chk("t3_wr1_after", 32'(instr1_fifo_wr), 32'd1);
        @(posedge clk); #1; host_valid = 1'b0;
        send(EN);
        dispatch("t3");
        queues_empty("t3");

        // 4: END as first word
        send(EN);
        repeat (3) @(negedge clk);
        chk("t4_ready", 32'(host_ready), 32'd1);
        chk("t4_loader_busy", 32'(loader_busy), 32'd0);
        chk("t4_seq_len", 32'(seq_len), 32'd2);
        @(posedge clk); #1;
        queues_empty("t4");

        // 5: reset while in WAIT_DONE
        send(A); send(B); send(C); send(EN);
        repeat (3) @(negedge clk);
        @(posedge clk); #1; dispatcher_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_busy", 32'(loader_busy), 32'd0);
        chk("t5_rst_wr0", 32'(instr0_fifo_wr), 32'd0);
        chk("t5_rst_wr1", 32'(instr1_fifo_wr), 32'd0);
        chk("t5_rst_seq_len", 32'(seq_len), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; dispatcher_busy = 1'b0;
        slot_m = 0; cnt_m = 0;
        @(posedge clk); #1;
        queues_empty("t5_pre");
        send(C); send(A); send(EN);
        dispatch("t5");
        queues_empty("t5");

        // 6: counter saturation, 2^16+4 words
        for (int i = 0; i < 65540; i++) send({4'h1, 28'(i)});
        send(EN);
        dispatch("t6");
        chk("t6_seq_len_sat", 32'(seq_len), 32'h0000_FFFF);
        queues_empty("t6");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
